// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: DEPTH-entry FIFO carrying a payload and write
// enables, with synchronous flush, occupancy output and a saturating bubble counter.
module pipe_stage_buf #(
  parameter int PAYLOAD_W = 64,
  parameter int WE_W      = 4,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 16,
  parameter int OCC_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [WE_W-1:0]      in_we,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [WE_W-1:0]      out_we,
  output logic [OCC_W-1:0]     occupancy,
  output logic [CNT_W-1:0]     bubble_cnt
);

  // Handshake: a transfer happens on an edge where valid && ready on that side.
  // in_ready never looks at in_valid; when full it follows out_ready
  // combinationally so a full buffer can still move one entry per cycle.

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  logic [PAYLOAD_W-1:0] payload_mem [DEPTH];
  logic [WE_W-1:0]      we_mem      [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [OCC_W-1:0]     occ;
  logic                 push;
  logic                 pop;

  assign out_valid = (occ != '0);
  assign in_ready  = flush || (occ < DEPTH_OCC) || out_ready;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign occupancy = occ;

  // An empty buffer presents a NOP so no stale write enable leaks downstream.
  assign out_payload = out_valid ? payload_mem[rd_ptr] : '0;
  assign out_we      = out_valid ? we_mem[rd_ptr]      : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      payload_mem[wr_ptr] <= in_payload;
      we_mem[wr_ptr]      <= in_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (out_ready && !out_valid && !flush && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed steps plus random traffic, every cycle
// compared against a queue-based model of the buffer.
module tb_pipe_stage_buf;

  localparam int PW    = 32;
  localparam int WW    = 4;
  localparam int DEPTH = 3;
  localparam int CW    = 4;
  localparam int OW    = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic [PW-1:0] payload;
    logic [WW-1:0] we;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_payload;
  logic [WW-1:0] in_we;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_payload;
  logic [WW-1:0] out_we;
  logic [OW-1:0] occupancy;
  logic [CW-1:0] bubble_cnt;

  entry_t exp_q[$];
  int     exp_bub = 0;
  int     errors = 0;
  int     checks = 0;

  pipe_stage_buf #(
    .PAYLOAD_W(PW), .WE_W(WW), .DEPTH(DEPTH), .CNT_W(CW), .OCC_W(OW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload), .out_we(out_we),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output to the model, then advance model and DUT by one edge.
  task automatic cycle();
    entry_t head;
    bit     ready_exp;
    #1;
    head      = (exp_q.size() != 0) ? exp_q[0] : '0;
    ready_exp = flush || (exp_q.size() < DEPTH) || out_ready;
    chk("out_valid",   64'(out_valid),   64'(exp_q.size() != 0));
    chk("out_payload", 64'(out_payload), 64'(head.payload));
    chk("out_we",      64'(out_we),      64'(head.we));
    chk("occupancy",   64'(occupancy),   64'(exp_q.size()));
    chk("in_ready",    64'(in_ready),    64'(ready_exp));
    chk("bubble_cnt",  64'(bubble_cnt),  64'(exp_bub));
    if (!rst) begin
      exp_q.delete();
      exp_bub = 0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (out_ready && exp_q.size() == 0 && exp_bub < CNT_MAX) exp_bub++;
      if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && ready_exp) exp_q.push_back('{payload: in_payload, we: in_we});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [PW-1:0] p, input logic [WW-1:0] w, input bit r);
    in_valid   = v;
    in_payload = p;
    in_we      = w;
    out_ready  = r;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    drive(1'b1, 32'h1111_0001, 4'b0011, 1'b0);
    @(posedge clk); #1;

    // reset held with in_valid high; first released edge takes the entry
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    chk("accept_after_reset", 64'(occupancy), 64'd1);

    // drain, then latency/order with out_ready high
    drive(1'b0, '0, '0, 1'b1); cycle();
    drive(1'b1, 32'hA, 4'b0001, 1'b1); cycle();
    chk("lat_head_A", 64'(out_payload), 64'hA);
    drive(1'b1, 32'hB, 4'b0010, 1'b1); cycle();
    chk("lat_head_B", 64'(out_payload), 64'hB);
    chk("lat_occ_1",  64'(occupancy),   64'd1);
    drive(1'b0, '0, '0, 1'b1); cycle();

    // fill under backpressure, then pass-through ready when full
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 4'(i), 1'b0); cycle();
    end
    drive(1'b1, 32'h200, 4'b0101, 1'b0); #1;
    chk("full_in_ready_0", 64'(in_ready), 64'd0);
    out_ready = 1'b1; #1;
    chk("full_in_ready_1", 64'(in_ready), 64'd1);
    cycle();
    chk("full_occ_held", 64'(occupancy), 64'(DEPTH));
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h300 + 32'(i), 4'(i), 1'b1); cycle();
    end
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle();

    // flush kills two buffered entries and the one pushed alongside it
    drive(1'b1, 32'h400, 4'b1111, 1'b0); cycle();
    drive(1'b1, 32'h401, 4'b1111, 1'b0); cycle();
    drive(1'b1, 32'h402, 4'b1111, 1'b1); flush = 1'b1; cycle();
    flush = 1'b0; drive(1'b0, '0, '0, 1'b0); #1;
    chk("flush_occ",   64'(occupancy), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_we",    64'(out_we),    64'd0);
    cycle(); cycle();

    // bubble counter: flush cycles do not count, saturates at max
    rst = 1'b0; cycle(); rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1);
    cycle(); cycle(); cycle();
    flush = 1'b1; cycle(); flush = 1'b0; #1;
    chk("bubble_flush_skip", 64'(bubble_cnt), 64'd3);
    for (int i = 0; i < 20; i++) cycle();
    chk("bubble_saturate", 64'(bubble_cnt), 64'(CNT_MAX));

    // reset in the middle of operation
    rst = 1'b0; cycle(); rst = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    drive(1'b1, 32'h500, 4'b1001, 1'b0); cycle();
    drive(1'b1, 32'h501, 4'b0110, 1'b0); cycle();
    chk("mid_occ_2",    64'(occupancy),  64'd2);
    chk("mid_bubble_5", 64'(bubble_cnt), 64'd5);
    rst = 1'b0; drive(1'b0, '0, '0, 1'b0); cycle(); rst = 1'b1; #1;
    chk("mid_rst_occ",    64'(occupancy),  64'd0);
    chk("mid_rst_bubble", 64'(bubble_cnt), 64'd0);
    chk("mid_rst_we",     64'(out_we),     64'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0));
      flush = ($urandom_range(0, 24) == 0);
      rst   = ($urandom_range(0, 59) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised pipeline-stage buffer that replaces the fixed stall/flush stage registers between core pipeline stages (EX/MEM, MEM/WB and successors). It carries a packed payload plus a write-enable vector through a DEPTH-entry elastic buffer with valid/ready handshake on both sides. It also provides synchronous flush that kills all in-flight write enables, an occupancy output, and a saturating bubble counter for performance monitoring. With DEPTH=1 it acts as a stage register that does not lose throughput.

Parameters:
PAYLOAD_W, 64, width of packed stage payload (data, addresses, hi/lo, cp0 fields)
WE_W, 4, number of write-enable bits (reg, hilo, cp0, LLbit)
DEPTH, 2, number of buffer entries; legal range 1..8, need not be a power of two
CNT_W, 16, width of bubble counter
OCC_W, 4, width of occupancy output; must satisfy 2^OCC_W > DEPTH

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
flush  in  1  synchronous kill of all buffered entries
in_valid  in  1  upstream stage presents an entry
in_ready  out  1  buffer accepts an entry this cycle
in_payload  in  PAYLOAD_W  upstream payload
in_we  in  WE_W  upstream write enables
out_valid  out  1  head entry valid toward downstream
out_ready  in  1  downstream consumes head this cycle
out_payload  out  PAYLOAD_W  head payload
out_we  out  WE_W  head write enables
occupancy  out  OCC_W  number of valid entries
bubble_cnt  out  CNT_W  cycles with out_ready=1 and out_valid=0, saturating

Behaviour:
- Reset (rst=0 at clock edge): all entries invalid, read/write pointers 0, occupancy=0, bubble_cnt=0. Reset has priority over flush and handshakes and applies mid-transfer.
- Transfers: push when in_valid && in_ready; pop when out_valid && out_ready.
- in_ready = (occupancy < DEPTH) || out_ready. When full, in_ready takes a combinational path from out_ready. This pass-through path is intentional and is the only combinational in-to-out path.
- in_ready does not depend on in_valid. in_ready is 1 during flush; entries pushed in a flush cycle are discarded.
- Latency: an entry pushed at edge N is visible at out_* after edge N. Minimum latency is 1 cycle. There is no bypass from in_* to out_*.
- Ordering: strict FIFO. The write pointer advances on push and the read pointer advances on pop. Both wrap from DEPTH-1 to 0.
- Simultaneous push and pop: occupancy is unchanged. This is legal when full (only through out_ready) and when holding one entry.
- Pop with push while occupancy=1: the new entry becomes head on the next cycle, with no bubble.
- out_valid = (occupancy != 0).
- When out_valid=0, out_payload and out_we are driven to all zeros so that the downstream sees a NOP and never a stale enable.
- Flush (rst=1, flush=1): on the next edge all entries are invalid, occupancy=0, and pointers reset to 0. out_we is 0 from then on.
  - Any push or pop in the flush cycle is ignored for buffer state.
  - Downstream must still sample out_* in the flush cycle as normal.
- occupancy: registered, exact count 0..DEPTH.
- bubble_cnt: increments by 1 on each edge where out_ready=1 && out_valid=0 && flush=0. It holds at 2^CNT_W-1 and has no wrap. It is cleared only by reset.
- Payload is stored without transformation. The width of every internal path equals PAYLOAD_W/WE_W exactly.
- DEPTH=1: behaves as a single register that can accept a new entry in the same cycle the old one leaves. Full throughput is sustained when out_ready=1.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with in_valid=1 -> out_valid=0, out_we=0, out_payload=0, occupancy=0, bubble_cnt=0; first edge with rst=1 accepts the entry.
2. Latency and order (DEPTH=2): push 0xA then 0xB on consecutive cycles with out_ready=1 -> out_payload=0xA one cycle after its push, then 0xB. Throughput is 1 per cycle and occupancy stays 1.
3. Full and backpressure (DEPTH=3): out_ready=0, push 3 entries -> occupancy=3 and in_ready=0. Raising out_ready with in_valid=1 gives in_ready=1 and occupancy stays 3. Entries exit in push order and pointers wrap correctly over 10 entries.
4. Flush: 2 entries with in_we=4'b1111, assert flush for 1 cycle while pushing a third -> next cycle occupancy=0, out_valid=0, out_we=0. The third entry never appears.
5. Bubble counter (CNT_W=4): out_ready=1 with an empty buffer for 20 cycles -> bubble_cnt reaches 15 and holds. Cycles with flush=1 do not count.
6. Reset mid-operation: occupancy=2 and bubble_cnt=5, drive rst=0 for 1 cycle -> all outputs return to reset values on the next edge.
